// File: rtl/branch_call_unit_if.sv
// Request/response bundle between the PC front end and branch_call_unit.
// master drives requests and the current pc; slave returns the next address and stack status.
interface branch_call_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 8
);
  localparam int SP_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  logic              jmp;
  logic              br_taken;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] offset;
  logic              clr_flags;
  logic [ADDR_W-1:0] load;
  logic              load_en;
  logic [SP_W-1:0]   sp;
  logic              stack_ovf;
  logic              stack_unf;

  modport master (
    output pc, jmp, br_taken, call, ret, target, offset, clr_flags,
    input  load, load_en, sp, stack_ovf, stack_unf
  );

  modport slave (
    input  pc, jmp, br_taken, call, ret, target, offset, clr_flags,
    output load, load_en, sp, stack_ovf, stack_unf
  );
endinterface

// File: rtl/branch_call_unit.sv
// Next-PC generator with hardware return stack; STACK_TRAP_EN redirects over/underflow to TRAP_VEC.
// Latency: load/load_en combinational from requests; stack, sp and flags update on the same edge.
// Backpressure: none, one request per cycle accepted at full rate (ret > call > jmp > br_taken).
module branch_call_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 8,
  parameter logic [ADDR_W-1:0] TRAP_VEC = 8'hFF
) (
  input logic               clk,
  input logic               reset,
  branch_call_unit_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SP_W  = PTR_W + 1;

`ifdef STACK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [ADDR_W-1:0] stack [DEPTH];
  logic [SP_W-1:0]   sp_q;
  logic              ovf_q;
  logic              unf_q;

  logic              full;
  logic              empty;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] ovf_addr;
  logic [ADDR_W-1:0] unf_addr;

  logic [ADDR_W-1:0] load_c;
  logic              load_en_c;
  logic              push;
  logic              pop;
  logic              set_ovf;
  logic              set_unf;

  assign full     = (sp_q == SP_W'(DEPTH));
  assign empty    = (sp_q == '0);
  assign wr_idx   = sp_q[PTR_W-1:0];
  // At sp==DEPTH the low bits wrap to 0, so minus one still lands on the top entry.
  assign top_idx  = wr_idx - PTR_W'(1);
  assign top      = stack[top_idx];
  assign pc_inc   = bus.pc + ADDR_W'(1);
  assign ovf_addr = TRAP_EN ? TRAP_VEC : bus.target;
  assign unf_addr = TRAP_EN ? TRAP_VEC : '0;

  always_comb begin
    load_c    = bus.pc;
    load_en_c = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (!reset) begin
      load_c = '0;
    end else if (bus.ret) begin
      load_en_c = 1'b1;
      if (empty) begin
        load_c  = unf_addr;
        set_unf = 1'b1;
      end else begin
        load_c = top;
        pop    = 1'b1;
      end
    end else if (bus.call) begin
      load_en_c = 1'b1;
      if (full) begin
        load_c  = ovf_addr;
        set_ovf = 1'b1;
      end else begin
        load_c = bus.target;
        push   = 1'b1;
      end
    end else if (bus.jmp) begin
      load_en_c = 1'b1;
      load_c    = bus.target;
    end else if (bus.br_taken) begin
      load_en_c = 1'b1;
      load_c    = pc_inc + bus.offset;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else begin
      if (push) begin
        stack[wr_idx] <= pc_inc;
        sp_q          <= sp_q + SP_W'(1);
      end else if (pop) begin
        sp_q <= sp_q - SP_W'(1);
      end
      // A flag being set this cycle takes precedence over a clear request.
      if (set_ovf)            ovf_q <= 1'b1;
      else if (bus.clr_flags) ovf_q <= 1'b0;
      if (set_unf)            unf_q <= 1'b1;
      else if (bus.clr_flags) unf_q <= 1'b0;
    end
  end

  assign bus.load      = load_c;
  assign bus.load_en   = load_en_c;
  assign bus.sp        = sp_q;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;
endmodule
